// File: rtl/sprite_mover.sv
// sprite_mover: moving sprite with per-frame motion FSM and 3-stage pixel path.
// Ports: i_clk/i_rst; i_x/i_y pixel in; i_v_sync frame tick (async);
//   i_is_finished/i_is_dead freeze; i_restart reload; o_rom_addr/i_rom_data
//   sprite ROM (1-cycle read); o_red/o_green/o_blue/o_sprite_hit pixel out;
//   o_visible/o_pos_x/o_pos_y sprite state.
module sprite_mover #(
  parameter int SPRITE_W       = 32,
  parameter int SCALE_SHIFT    = 2,
  parameter int PIX_BITS       = 2,
  parameter logic [24*(1<<PIX_BITS)-1:0] PALETTE =
    {24'h000000, 24'h9ad2ff, 24'h4f92b3, 24'hffffff},
  parameter int SCREEN_W       = 1280,
  parameter int SCREEN_H       = 720,
  parameter int START_X        = 876,
  parameter int START_Y        = 296,
  parameter int VEL_X          = 1,
  parameter int VEL_Y          = 1,
  parameter int EDGE_MODE      = 0,
  parameter int RESPAWN_FRAMES = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [15:0]                     i_x,
  input  logic [15:0]                     i_y,
  input  logic                            i_v_sync,
  input  logic                            i_is_finished,
  input  logic                            i_is_dead,
  input  logic                            i_restart,
  output logic [2*$clog2(SPRITE_W)-1:0]   o_rom_addr,
  input  logic [PIX_BITS-1:0]             i_rom_data,
  output logic [7:0]                      o_red,
  output logic [7:0]                      o_green,
  output logic [7:0]                      o_blue,
  output logic                            o_sprite_hit,
  output logic                            o_visible,
  output logic [15:0]                     o_pos_x,
  output logic [15:0]                     o_pos_y
);

  localparam int AW   = $clog2(SPRITE_W);
  localparam int SIZE = SPRITE_W << SCALE_SHIFT;
  localparam int NPAL = 1 << PIX_BITS;
  localparam int CW   =
    (RESPAWN_FRAMES > 0) ? $clog2(RESPAWN_FRAMES + 1) : 1;

  localparam logic signed [16:0] XMAX = 17'(SCREEN_W - SIZE);
  localparam logic signed [16:0] YMAX = 17'(SCREEN_H - SIZE);

  typedef enum logic {
    MOVING,
    HIDDEN
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        pos_x_q, pos_x_d;
  logic [15:0]        pos_y_q, pos_y_d;
  logic signed [7:0]  vel_x_q, vel_x_d;
  logic signed [7:0]  vel_y_q, vel_y_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic vs_s1, vs_s2, vs_s3;
  logic tick;
  logic freeze;

  logic signed [16:0] next_x, next_y;
  logic               low_x, low_y;
  logic               out_x, out_y;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
      vs_s3 <= 1'b0;
    end else begin
      vs_s1 <= i_v_sync;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
    end
  end

  assign tick   = vs_s2 & ~vs_s3;
  assign freeze = i_is_finished | i_is_dead;

  assign next_x = $signed({1'b0, pos_x_q})
                + $signed({{9{vel_x_q[7]}}, vel_x_q});
  assign next_y = $signed({1'b0, pos_y_q})
                + $signed({{9{vel_y_q[7]}}, vel_y_q});

  assign low_x = next_x[16];
  assign low_y = next_y[16];
  assign out_x = low_x | (next_x > XMAX);
  assign out_y = low_y | (next_y > YMAX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= MOVING;
      pos_x_q <= 16'(START_X);
      pos_y_q <= 16'(START_Y);
      vel_x_q <= 8'(VEL_X);
      vel_y_q <= 8'(VEL_Y);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      vel_x_q <= vel_x_d;
      vel_y_q <= vel_y_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    vel_x_d = vel_x_q;
    vel_y_d = vel_y_q;
    cnt_d   = cnt_q;
    if (i_restart) begin
      state_d = MOVING;
      pos_x_d = 16'(START_X);
      pos_y_d = 16'(START_Y);
      vel_x_d = 8'(VEL_X);
      vel_y_d = 8'(VEL_Y);
    end else if (tick && !freeze) begin
      unique case (state_q)
        MOVING: begin
          if (EDGE_MODE == 0) begin
            if (out_x || out_y) begin
              state_d = HIDDEN;
              cnt_d   = CW'(RESPAWN_FRAMES);
            end else begin
              pos_x_d = next_x[15:0];
              pos_y_d = next_y[15:0];
            end
          end else begin
            // each axis clamps to the bound it crossed and reflects
            if (out_x) begin
              pos_x_d = low_x ? 16'd0 : XMAX[15:0];
              vel_x_d = -vel_x_q;
            end else begin
              pos_x_d = next_x[15:0];
            end
            if (out_y) begin
              pos_y_d = low_y ? 16'd0 : YMAX[15:0];
              vel_y_d = -vel_y_q;
            end else begin
              pos_y_d = next_y[15:0];
            end
          end
        end
        HIDDEN: begin
          if (cnt_q == '0) begin
            state_d = MOVING;
            pos_x_d = 16'(START_X);
            pos_y_d = 16'(START_Y);
            vel_x_d = 8'(VEL_X);
            vel_y_d = 8'(VEL_Y);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      endcase
    end
  end

  assign o_visible = (state_q == MOVING);
  assign o_pos_x   = pos_x_q;
  assign o_pos_y   = pos_y_q;

  logic [16:0]    x_ext, y_ext;
  logic           in_box;
  logic [AW-1:0]  tex_x, tex_y;
  logic           s1_in, s2_in;
  logic [23:0]    pal_rgb;

  assign x_ext  = {1'b0, i_x};
  assign y_ext  = {1'b0, i_y};
  assign in_box = (x_ext >= {1'b0, pos_x_q})
               && (x_ext <  {1'b0, pos_x_q} + 17'(SIZE))
               && (y_ext >= {1'b0, pos_y_q})
               && (y_ext <  {1'b0, pos_y_q} + 17'(SIZE))
               && (state_q == MOVING);
  assign tex_x  = AW'((i_x - pos_x_q) >> SCALE_SHIFT);
  assign tex_y  = AW'((i_y - pos_y_q) >> SCALE_SHIFT);

  // entry 0 sits in the top bits of the packed palette
  always_comb begin
    pal_rgb = '0;
    for (int i = 0; i < NPAL; i++) begin
      if (i_rom_data == PIX_BITS'(i))
        pal_rgb = PALETTE[(NPAL-1-i)*24 +: 24];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_in        <= 1'b0;
      s2_in        <= 1'b0;
      o_rom_addr   <= '0;
      o_red        <= '0;
      o_green      <= '0;
      o_blue       <= '0;
      o_sprite_hit <= 1'b0;
    end else begin
      s1_in      <= in_box;
      o_rom_addr <= {tex_y, tex_x};
      s2_in      <= s1_in;
      if (s2_in) begin
        o_red        <= pal_rgb[23:16];
        o_green      <= pal_rgb[15:8];
        o_blue       <= pal_rgb[7:0];
        o_sprite_hit <= (i_rom_data != '0);
      end else begin
        o_red        <= '0;
        o_green      <= '0;
        o_blue       <= '0;
        o_sprite_hit <= 1'b0;
      end
    end
  end

endmodule
